// File: rtl/jtdd_rom_arb.sv
// Arbitrates one SDRAM read port among the char, scroll and object ROM clients.
// Each client keeps a one-word cache; misses are served round-robin, one word at a time.
module jtdd_rom_arb #(
  parameter logic [21:0] CHAR_OFFSET = 22'h00000,
  parameter logic [21:0] SCR_OFFSET  = 22'h08000,
  parameter logic [21:0] OBJ_OFFSET  = 22'h18000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        char_cs,
  input  logic [15:0] char_addr,
  output logic [7:0]  char_data,
  output logic        char_ok,
  input  logic        scr_cs,
  input  logic [16:0] scr_addr,
  output logic [15:0] scr_data,
  output logic        scr_ok,
  input  logic        obj_cs,
  input  logic [18:0] obj_addr,
  output logic [15:0] obj_data,
  output logic        obj_ok,
  output logic [21:0] sdram_addr,
  output logic        sdram_req,
  input  logic        sdram_ack,
  input  logic        sdram_rdy,
  input  logic [15:0] sdram_din
);

  localparam int unsigned AW = 22;
  localparam int unsigned DW = 16;
  localparam int unsigned FW = 19;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT_ACK, ST_WAIT_RDY, ST_DONE} state_t;
  typedef enum logic [1:0] {CL_CHAR = 2'd0, CL_SCR = 2'd1, CL_OBJ = 2'd2} client_t;

  state_t          state_q, state_d;
  client_t         gnt_q, gnt_d;
  client_t         last_q;
  logic [FW-1:0]   fl_addr_q, fl_addr_d;
  logic [AW-1:0]   sdram_addr_q, sdram_addr_d;
  logic            sdram_req_q, sdram_req_d;
  logic            fill;

  logic [2:0]      valid_q;
  logic [14:0]     char_tag_q;
  logic [16:0]     scr_tag_q;
  logic [18:0]     obj_tag_q;
  logic [DW-1:0]   char_word_q, scr_word_q, obj_word_q;

  logic [2:0]      pending;
  logic            pick_valid;
  client_t         pick;
  logic [FW-1:0]   pick_addr;
  logic [AW-1:0]   pick_sdram;

  // Hit detection is combinational so a changed address drops ok immediately
  assign char_ok   = char_cs & valid_q[0] & (char_tag_q == char_addr[15:1]);
  assign scr_ok    = scr_cs  & valid_q[1] & (scr_tag_q  == scr_addr);
  assign obj_ok    = obj_cs  & valid_q[2] & (obj_tag_q  == obj_addr);
  assign char_data = char_addr[0] ? char_word_q[15:8] : char_word_q[7:0];
  assign scr_data  = scr_word_q;
  assign obj_data  = obj_word_q;
  assign sdram_addr = sdram_addr_q;
  assign sdram_req  = sdram_req_q;

  assign pending    = {obj_cs & ~obj_ok, scr_cs & ~scr_ok, char_cs & ~char_ok};
  assign pick_valid = |pending;

  // Round-robin: search starts at the client after the last one served
  always_comb begin
    pick = CL_CHAR;
    unique case (last_q)
      CL_CHAR: begin
        if (pending[1])      pick = CL_SCR;
        else if (pending[2]) pick = CL_OBJ;
        else                 pick = CL_CHAR;
      end
      CL_SCR: begin
        if (pending[2])      pick = CL_OBJ;
        else if (pending[0]) pick = CL_CHAR;
        else                 pick = CL_SCR;
      end
      default: begin
        if (pending[0])      pick = CL_CHAR;
        else if (pending[1]) pick = CL_SCR;
        else                 pick = CL_OBJ;
      end
    endcase
  end

  always_comb begin
    pick_addr  = FW'(char_addr);
    pick_sdram = CHAR_OFFSET + AW'(char_addr[15:1]);
    unique case (pick)
      CL_SCR: begin
        pick_addr  = FW'(scr_addr);
        pick_sdram = SCR_OFFSET + AW'(scr_addr);
      end
      CL_OBJ: begin
        pick_addr  = obj_addr;
        pick_sdram = OBJ_OFFSET + AW'(obj_addr);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    fl_addr_d    = fl_addr_q;
    sdram_addr_d = sdram_addr_q;
    sdram_req_d  = sdram_req_q;
    fill         = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          gnt_d        = pick;
          fl_addr_d    = pick_addr;
          sdram_addr_d = pick_sdram;
          sdram_req_d  = 1'b1;
          state_d      = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (sdram_ack) begin
          sdram_req_d = 1'b0;
          if (sdram_rdy) begin
            fill    = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_WAIT_RDY;
          end
        end
      end
      ST_WAIT_RDY: begin
        if (sdram_rdy) begin
          fill    = 1'b1;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      gnt_q        <= CL_CHAR;
      fl_addr_q    <= '0;
      sdram_addr_q <= '0;
      sdram_req_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      fl_addr_q    <= fl_addr_d;
      sdram_addr_q <= sdram_addr_d;
      sdram_req_q  <= sdram_req_d;
    end
  end

  // Cache fill stores the address latched at grant, even if the client has moved on
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= '0;
      last_q      <= CL_OBJ;
      char_tag_q  <= '0;
      scr_tag_q   <= '0;
      obj_tag_q   <= '0;
      char_word_q <= '0;
      scr_word_q  <= '0;
      obj_word_q  <= '0;
    end else if (fill) begin
      last_q <= gnt_q;
      unique case (gnt_q)
        CL_SCR: begin
          valid_q[1] <= 1'b1;
          scr_tag_q  <= fl_addr_q[16:0];
          scr_word_q <= sdram_din;
        end
        CL_OBJ: begin
          valid_q[2] <= 1'b1;
          obj_tag_q  <= fl_addr_q;
          obj_word_q <= sdram_din;
        end
        default: begin
          valid_q[0]  <= 1'b1;
          char_tag_q  <= fl_addr_q[15:1];
          char_word_q <= sdram_din;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtdd_rom_arb.sv
// Randomised bench for jtdd_rom_arb: SDRAM responder, transaction-level reference model
// and a scoreboard that matches every issued SDRAM address against the model's grant.
module tb_jtdd_rom_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        char_cs, scr_cs, obj_cs;
  logic [15:0] char_addr;
  logic [16:0] scr_addr;
  logic [18:0] obj_addr;
  logic [7:0]  char_data;
  logic [15:0] scr_data, obj_data;
  logic        char_ok, scr_ok, obj_ok;
  logic [21:0] sdram_addr;
  logic        sdram_req;
  logic        sdram_ack = 1'b0, sdram_rdy = 1'b0;
  logic [15:0] sdram_din = 16'h0;

  int checks = 0;
  int errors = 0;

  jtdd_rom_arb dut (
    .clk(clk), .rst_n(rst_n),
    .char_cs(char_cs), .char_addr(char_addr), .char_data(char_data), .char_ok(char_ok),
    .scr_cs(scr_cs), .scr_addr(scr_addr), .scr_data(scr_data), .scr_ok(scr_ok),
    .obj_cs(obj_cs), .obj_addr(obj_addr), .obj_data(obj_data), .obj_ok(obj_ok),
    .sdram_addr(sdram_addr), .sdram_req(sdram_req), .sdram_ack(sdram_ack),
    .sdram_rdy(sdram_rdy), .sdram_din(sdram_din)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  bit          m_valid [3];
  logic [18:0] m_tag   [3];
  logic [15:0] m_data  [3];
  int          m_last  = 2;
  int          m_phase = 0;   // 0 free, 1 request out, 2 waiting data, 3 settle cycle
  int          m_gnt   = 0;
  logic [18:0] m_fl;
  logic [21:0] m_hold  = '0;
  int          waits   [3];
  int          max_wait = 0;
  logic [21:0] exp_q[$];
  logic [21:0] grant_log[$];
  int          req_rises = 0;
  logic        prev_req = 1'b0;

  function automatic logic [18:0] cur(input int c);
    case (c)
      0:       return 19'(char_addr[15:1]);
      1:       return 19'(scr_addr);
      default: return obj_addr;
    endcase
  endfunction

  function automatic bit cs_of(input int c);
    case (c)
      0:       return char_cs;
      1:       return scr_cs;
      default: return obj_cs;
    endcase
  endfunction

  function automatic bit m_ok(input int c);
    return cs_of(c) && m_valid[c] && (m_tag[c] == cur(c));
  endfunction

  function automatic logic [21:0] m_target(input int c);
    int unsigned off;
    off = (c == 0) ? 32'h0 : (c == 1) ? 32'h8000 : 32'h18000;
    return 22'((off + 32'(cur(c))) % 32'h400000);
  endfunction

  task automatic m_fill();
    m_valid[m_gnt] = 1'b1;
    m_tag[m_gnt]   = m_fl;
    m_data[m_gnt]  = sdram_din;
    m_last         = m_gnt;
  endtask

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      for (int c = 0; c < 3; c++) begin
        m_valid[c] = 1'b0; m_tag[c] = '0; m_data[c] = '0; waits[c] = 0;
      end
      m_last = 2; m_phase = 0; m_hold = '0;
      exp_q.delete();
    end else begin
      case (m_phase)
        0: begin
          bit pend [3];
          int g;
          g = -1;
          for (int c = 0; c < 3; c++) pend[c] = cs_of(c) && !m_ok(c);
          for (int k = 1; k <= 3; k++)
            if (g < 0 && pend[(m_last + k) % 3]) g = (m_last + k) % 3;
          if (g >= 0) begin
            m_gnt  = g;
            m_fl   = cur(g);
            m_hold = m_target(g);
            exp_q.push_back(m_hold);
            for (int c = 0; c < 3; c++) begin
              if (c == g || !pend[c]) waits[c] = 0;
              else waits[c]++;
              if (waits[c] > max_wait) max_wait = waits[c];
            end
            m_phase = 1;
          end
        end
        1: if (sdram_ack) begin
             if (sdram_rdy) begin m_fill(); m_phase = 3; end
             else m_phase = 2;
           end
        2: if (sdram_rdy) begin m_fill(); m_phase = 3; end
        default: m_phase = 0;
      endcase
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(posedge clk) begin
    #2;
    if (sdram_req && !prev_req) begin
      req_rises++;
      grant_log.push_back(sdram_addr);
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_unexpected_req actual=%h required=none", sdram_addr);
      end else begin
        chk("sb_sdram_addr", 32'(sdram_addr), 32'(exp_q.pop_front()));
      end
    end
    prev_req = sdram_req;
    chk("sdram_req", 32'(sdram_req), 32'(m_phase == 1));
    chk("sdram_addr_hold", 32'(sdram_addr), 32'(m_hold));
    chk("char_ok", 32'(char_ok), 32'(m_ok(0)));
    chk("scr_ok", 32'(scr_ok), 32'(m_ok(1)));
    chk("obj_ok", 32'(obj_ok), 32'(m_ok(2)));
    chk("char_data", 32'(char_data), 32'(char_addr[0] ? m_data[0][15:8] : m_data[0][7:0]));
    chk("scr_data", 32'(scr_data), 32'(m_data[1]));
    chk("obj_data", 32'(obj_data), 32'(m_data[2]));
  end

  // ---------------- SDRAM responder ----------------
  bit          busy = 1'b0, acked = 1'b0, fixed_mode = 1'b1;
  int          ack_cnt = 0, rdy_cnt = 0;
  logic [15:0] fixed_data = 16'hA55A;
  int          inj_req = 0, inj_seen = 0;

  always @(negedge clk) begin
    #2;
    sdram_ack = 1'b0;
    sdram_rdy = 1'b0;
    if (!rst_n) begin
      busy = 1'b0;
    end else if (busy) begin
      if (!acked) begin
        if (ack_cnt == 0) begin sdram_ack = 1'b1; acked = 1'b1; end
        else ack_cnt--;
      end
      if (rdy_cnt == 0) begin
        sdram_rdy = 1'b1;
        sdram_din = fixed_mode ? fixed_data : 16'($urandom);
        busy = 1'b0;
      end else rdy_cnt--;
    end else if (sdram_req) begin
      busy    = 1'b1;
      acked   = 1'b0;
      ack_cnt = fixed_mode ? 1 : int'($urandom_range(0, 3));
      rdy_cnt = ack_cnt + (fixed_mode ? 3 : int'($urandom_range(0, 4)));
    end else if (inj_req != inj_seen) begin
      inj_seen  = inj_req;
      sdram_rdy = 1'b1;
      sdram_din = 16'hDEAD;
    end
  end

  function automatic bit logged(input int from, input logic [21:0] v);
    for (int i = from; i < grant_log.size(); i++) if (grant_log[i] == v) return 1'b1;
    return 1'b0;
  endfunction

  task automatic wait_for(input string name, input int which, input int budget);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      case (which)
        0: hit = char_ok;
        1: hit = scr_ok;
        2: hit = char_ok && scr_ok && obj_ok;
        default: hit = (m_phase == 2);
      endcase
    end
    chk(name, 32'(hit), 32'(1));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n0, r0;
    logic [7:0]  d_c;
    logic [15:0] d_s, d_o;
    rst_n = 1'b0;
    char_cs = 1'b0; scr_cs = 1'b0; obj_cs = 1'b0;
    char_addr = '0; scr_addr = '0; obj_addr = '0;
    repeat (3) @(negedge clk);
    chk("rst_ok", 32'({char_ok, scr_ok, obj_ok, sdram_req}), 32'(0));
    chk("rst_addr", 32'(sdram_addr), 32'(0));
    rst_n = 1'b1;

    // single char miss, then high byte of the returned word
    @(negedge clk);
    char_cs = 1'b1; char_addr = 16'h0003;
    wait_for("t1_char_ok", 0, 60);
    chk("t1_char_data", 32'(char_data), 32'(8'hA5));
    chk("t1_sdram_addr", 32'(grant_log[grant_log.size() - 1]), 32'(22'h000001));

    // all three pending at once
    fixed_mode = 1'b0;
    n0 = grant_log.size();
    char_addr = 16'h0010; scr_cs = 1'b1; scr_addr = 17'h00010;
    obj_cs = 1'b1; obj_addr = 19'h00020;
    wait_for("t2_all_ok", 2, 200);
    chk("t2_grants", 32'(grant_log.size() - n0), 32'(3));
    chk("t2_char", 32'(logged(n0, 22'h000008)), 32'(1));
    chk("t2_scr", 32'(logged(n0, 22'h008010)), 32'(1));
    chk("t2_obj", 32'(logged(n0, 22'h018020)), 32'(1));

    // scroll address moves between ack and rdy
    fixed_mode = 1'b1;
    n0 = grant_log.size();
    scr_addr = 17'h1;
    wait_for("t3_wait_rdy", 3, 60);
    scr_addr = 17'h2;
    @(negedge clk);
    chk("t3_scr_ok_low", 32'(scr_ok), 32'(0));
    wait_for("t3_scr_ok", 1, 100);
    chk("t3_first", 32'(logged(n0, 22'h008001)), 32'(1));
    chk("t3_second", 32'(grant_log[grant_log.size() - 1]), 32'(22'h008002));

    // steady hits: nothing requested, data stable
    r0 = req_rises; d_c = char_data; d_s = scr_data; d_o = obj_data;
    repeat (100) @(negedge clk);
    chk("t4_no_req", 32'(req_rises - r0), 32'(0));
    chk("t4_oks", 32'({char_ok, scr_ok, obj_ok}), 32'(3'b111));
    chk("t4_data", 32'({d_c, d_s, d_o}), 32'({char_data, scr_data, obj_data}));

    // reset while waiting for data, then a stray rdy
    char_addr = 16'h0100;
    wait_for("t5_wait_rdy", 3, 60);
    rst_n = 1'b0;
    char_cs = 1'b0; scr_cs = 1'b0; obj_cs = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    inj_req++;
    repeat (4) @(negedge clk);
    chk("t5_req", 32'(sdram_req), 32'(0));
    chk("t5_data", 32'({char_data, scr_data, obj_data}), 32'(0));
    char_cs = 1'b1; scr_cs = 1'b1; obj_cs = 1'b1;
    chk("t5_ok", 32'({char_ok, scr_ok, obj_ok}), 32'(0));

    // random traffic with obj hungry
    fixed_mode = 1'b0;
    max_wait = 0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 15) == 0) char_cs = 1'($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) scr_cs  = 1'($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0)  char_addr = 16'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0)  scr_addr  = 17'($urandom_range(0, 7));
      if (obj_ok || $urandom_range(0, 30) == 0) obj_addr = 19'($urandom);
      if ($urandom_range(0, 200) == 0) obj_addr = 19'h7FFFF;
    end
    chk("t6_starve", 32'(max_wait <= 2), 32'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
